// File: rtl/tc_vec_abs_pipe.sv
// Two-stage pipelined two's-complement magnitude unit with per-lane precision and chunk-level borrow chaining.
// Optional most-negative overflow detection is enabled by defining TC_OVF_DETECT_EN.
module tc_vec_abs_pipe #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8,
  parameter int NCHUNK  = DATA_W / CHUNK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [1:0]        in_prec,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mag,
  output logic [NCHUNK-1:0] out_sign,
  output logic [1:0]        out_prec,
  output logic [NCHUNK-1:0] out_ovf
);

  // Widest selectable precision is the whole vector: 2 for 32 bits, 3 for 64 bits.
  localparam logic [1:0] MAXP = 2'($clog2(NCHUNK));

  function automatic logic [1:0] effPrec(input logic [1:0] p);
    return (p > MAXP) ? MAXP : p;
  endfunction

  function automatic int laneMask(input logic [1:0] p);
    return (1 << effPrec(p)) - 1;
  endfunction

  // Find-first-one negation: bits up to and including the lowest one pass, higher bits invert.
  function automatic logic [CHUNK_W-1:0] ffoNeg(input logic [CHUNK_W-1:0] v);
    logic                seen;
    logic [CHUNK_W-1:0]  r;
    seen = 1'b0;
    r    = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      r[i] = v[i] ^ seen;
      seen = seen | v[i];
    end
    return r;
  endfunction

  logic              s1_ready, s2_ready;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_a_q;
  logic [1:0]        s1_prec_q;
  logic [NCHUNK-1:0] s1_sign_q, s1_sign_d;
  logic [NCHUNK-1:0] s1_any_q, s1_any_d;
  logic [DATA_W-1:0] s1_x0_q, s1_x0_d;
  logic [DATA_W-1:0] s1_x1_q, s1_x1_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [NCHUNK-1:0] sign_q;
  logic [1:0]        prec_q;

  logic [NCHUNK-1:0] cin_w;
  logic [NCHUNK:0]   chain_w;

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;

  assign s1_valid_d  = s1_ready ? in_valid : s1_valid_q;
  assign out_valid_d = s2_ready ? s1_valid_q : out_valid_q;

  // Stage 1 precompute: lane sign from the lane's top chunk, plus both candidate chunk results.
  always_comb begin
    s1_sign_d = '0;
    s1_any_d  = '0;
    s1_x0_d   = '0;
    s1_x1_d   = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      s1_any_d[k]                      = |in_a[k*CHUNK_W +: CHUNK_W];
      s1_x0_d[k*CHUNK_W +: CHUNK_W]    = ffoNeg(in_a[k*CHUNK_W +: CHUNK_W]);
      s1_x1_d[k*CHUNK_W +: CHUNK_W]    = ~in_a[k*CHUNK_W +: CHUNK_W];
      s1_sign_d[k] = in_signed &
                     in_a[(k | laneMask(in_prec))*CHUNK_W + CHUNK_W - 1];
    end
  end

  // Stage 2: OR-carry prefix restarts at the lowest chunk of every lane.
  always_comb begin
    cin_w      = '0;
    chain_w    = '0;
    mag_d      = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      cin_w[k]       = ((k & laneMask(s1_prec_q)) == 0) ? 1'b0 : chain_w[k];
      chain_w[k+1]   = cin_w[k] | s1_any_q[k];
      if (s1_sign_q[k]) begin
        mag_d[k*CHUNK_W +: CHUNK_W] = cin_w[k] ? s1_x1_q[k*CHUNK_W +: CHUNK_W]
                                               : s1_x0_q[k*CHUNK_W +: CHUNK_W];
      end else begin
        mag_d[k*CHUNK_W +: CHUNK_W] = s1_a_q[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_prec_q  <= '0;
      s1_sign_q  <= '0;
      s1_any_q   <= '0;
      s1_x0_q    <= '0;
      s1_x1_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_valid && s1_ready) begin
        s1_a_q    <= in_a;
        s1_prec_q <= in_prec;
        s1_sign_q <= s1_sign_d;
        s1_any_q  <= s1_any_d;
        s1_x0_q   <= s1_x0_d;
        s1_x1_q   <= s1_x1_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      sign_q      <= '0;
      prec_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s1_valid_q && s2_ready) begin
        mag_q  <= mag_d;
        sign_q <= s1_sign_q;
        prec_q <= s1_prec_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_mag   = mag_q;
  assign out_sign  = sign_q;
  assign out_prec  = prec_q;

`ifdef TC_OVF_DETECT_EN
  localparam logic [CHUNK_W-1:0] CHUNK_MIN = {1'b1, {(CHUNK_W-1){1'b0}}};

  logic [NCHUNK-1:0] ovf_q, ovf_d;

  // A signed lane overflows when its top chunk is 0x80 and every lower chunk of the lane is zero.
  always_comb begin
    ovf_d = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      ovf_d[k] = s1_sign_q[k];
      for (int j = 0; j < NCHUNK; j++) begin
        if (j >= (k & ~laneMask(s1_prec_q)) && j <= (k | laneMask(s1_prec_q))) begin
          if (j == (k | laneMask(s1_prec_q))) begin
            ovf_d[k] = ovf_d[k] & (s1_a_q[j*CHUNK_W +: CHUNK_W] == CHUNK_MIN);
          end else begin
            ovf_d[k] = ovf_d[k] & !s1_any_q[j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else if (s1_valid_q && s2_ready) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`else
  assign out_ovf = '0;
`endif

endmodule

// File: tb/tb_tc_vec_abs_pipe.sv
// Directed self-checking bench for tc_vec_abs_pipe (DATA_W=32): latency, lane boundaries, backpressure,
// streaming and mid-flight reset.
module tb_tc_vec_abs_pipe;

  localparam int DATA_W = 32;
  localparam int NCHUNK = 4;
`ifdef TC_OVF_DETECT_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [1:0]        in_prec;
  logic              in_signed;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_mag;
  logic [NCHUNK-1:0] out_sign;
  logic [1:0]        out_prec;
  logic [NCHUNK-1:0] out_ovf;

  int errors = 0;
  int checks = 0;

  // Hand-computed vectors, all signed.
  logic [31:0] tblA    [8] = '{32'h80FF7F01, 32'hFFFE8000, 32'hFFFFFF00, 32'h80000000,
                               32'hFF01FF01, 32'hFF01FF01, 32'h1234FFFF, 32'hFE00C0FF};
  logic [1:0]  tblP    [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00};
  logic [31:0] expMag  [8] = '{32'h80017F01, 32'h00028000, 32'h00000100, 32'h80000000,
                               32'h01010101, 32'h00FF00FF, 32'h12340001, 32'h02004001};
  logic [3:0]  expSign [8] = '{4'b1100, 4'b1111, 4'b1111, 4'b1111,
                               4'b1010, 4'b1111, 4'b0011, 4'b1011};
  logic [3:0]  expOvf  [8] = '{4'b1000, 4'b0011, 4'b0000, 4'b1111,
                               4'b0000, 4'b0000, 4'b0000, 4'b0000};

  tc_vec_abs_pipe #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_prec   (in_prec),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_sign  (out_sign),
    .out_prec  (out_prec),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [1:0] p, input logic s);
    in_a      = a;
    in_prec   = p;
    in_signed = s;
    in_valid  = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [31:0] eMag, input logic [3:0] eSign,
                           input logic [1:0] eP, input logic [3:0] eOvfOn);
    checkOutput({tag, "/valid"}, out_valid, 1);
    checkOutput({tag, "/mag"},   out_mag,   eMag);
    checkOutput({tag, "/sign"},  out_sign,  eSign);
    checkOutput({tag, "/prec"},  out_prec,  eP);
    checkOutput({tag, "/ovf"},   out_ovf,   OVF_ON ? eOvfOn : 4'b0000);
  endtask

  task automatic checkIdx(input string tag, input int i);
    checkBeat(tag, expMag[i], expSign[i], tblP[i], expOvf[i]);
  endtask

  task automatic runSingle(input string tag, input logic [31:0] a, input logic [1:0] p,
                           input logic s, input logic [31:0] eMag, input logic [3:0] eSign,
                           input logic [3:0] eOvfOn);
    applyStimulus(a, p, s);
    checkOutput({tag, "/in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    checkOutput({tag, "/early_valid"}, out_valid, 0);
    step();
    checkBeat(tag, eMag, eSign, p, eOvfOn);
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_prec   = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    checkOutput("rst/valid", out_valid, 0);
    checkOutput("rst/mag",   out_mag,   0);
    checkOutput("rst/sign",  out_sign,  0);
    checkOutput("rst/prec",  out_prec,  0);
    checkOutput("rst/ovf",   out_ovf,   0);
    rst_n = 1'b1;
    step();
    checkOutput("rst/in_ready", in_ready, 1);

    $display("[TB] directed single beats");
    runSingle("p0_mix",    32'h80FF7F01, 2'b00, 1'b1, 32'h80017F01, 4'b1100, 4'b1000);
    runSingle("p1_min",    32'hFFFE8000, 2'b01, 1'b1, 32'h00028000, 4'b1111, 4'b0011);
    runSingle("p2_neg",    32'hFFFFFF00, 2'b10, 1'b1, 32'h00000100, 4'b1111, 4'b0000);
    runSingle("p2_uns",    32'hFFFFFF00, 2'b10, 1'b0, 32'hFFFFFF00, 4'b0000, 4'b0000);
    runSingle("p0_zero",   32'h00000000, 2'b00, 1'b1, 32'h00000000, 4'b0000, 4'b0000);
    runSingle("p2_near",   32'h80000001, 2'b10, 1'b1, 32'h7FFFFFFF, 4'b1111, 4'b0000);
    runSingle("p1_hi",     32'h80010100, 2'b01, 1'b1, 32'h7FFF0100, 4'b1100, 4'b0000);
    runSingle("p2_carry",  32'hFFFF0000, 2'b10, 1'b1, 32'h00010000, 4'b1111, 4'b0000);
    runSingle("p3_clamp",  32'h80000000, 2'b11, 1'b1, 32'h80000000, 4'b1111, 4'b1111);
    runSingle("p0_bound",  32'hFF01FF01, 2'b00, 1'b1, 32'h01010101, 4'b1010, 4'b0000);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(tblA[0], tblP[0], 1'b1);
    step();
    checkOutput("bp/ready_after_A", in_ready, 1);
    applyStimulus(tblA[1], tblP[1], 1'b1);
    step();
    checkOutput("bp/ready_after_B", in_ready, 0);
    checkIdx("bp/A_head", 0);
    applyStimulus(tblA[2], tblP[2], 1'b1);
    step();
    checkOutput("bp/C_held", in_ready, 0);
    checkIdx("bp/A_stable1", 0);
    step();
    checkIdx("bp/A_stable2", 0);
    out_ready = 1'b1;
    #1;
    checkOutput("bp/ready_on_release", in_ready, 1);
    step();
    in_valid = 1'b0;
    checkIdx("bp/B_out", 1);
    step();
    checkIdx("bp/C_out", 2);
    step();
    checkOutput("bp/drained", out_valid, 0);

    $display("[TB] streaming");
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        applyStimulus(tblA[i], tblP[i], 1'b1);
        checkOutput($sformatf("st/in_ready%0d", i), in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1) checkIdx($sformatf("st/beat%0d", i - 1), i - 1);
    end
    step();
    checkOutput("st/drained", out_valid, 0);

    $display("[TB] reset mid-flight");
    out_ready = 1'b0;
    applyStimulus(tblA[3], tblP[3], 1'b1);
    step();
    applyStimulus(tblA[4], tblP[4], 1'b1);
    step();
    in_valid = 1'b0;
    checkOutput("mr/loaded", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mr/valid", out_valid, 0);
    checkOutput("mr/mag",   out_mag,   0);
    checkOutput("mr/sign",  out_sign,  0);
    checkOutput("mr/prec",  out_prec,  0);
    checkOutput("mr/ovf",   out_ovf,   0);
    step();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    checkOutput("mr/no_stale1", out_valid, 0);
    step();
    checkOutput("mr/no_stale2", out_valid, 0);
    runSingle("mr/new", 32'hFF01FF01, 2'b01, 1'b1, 32'h00FF00FF, 4'b1111, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
